rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_pkg.sv | 34 +++
 rtl/rf_wb_fifo.sv | 63 ++++++
 rtl/rf_wb_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_pkg
// Description : Shared types and constants for the register-file write-back
//               arbiter: the write-request record, the arbiter state
//               encoding and the default starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

    localparam int c_addr_w               = 5;
    localparam int c_data_w               = 32;
    localparam int c_default_starve_limit = 3;

    // One register-file write: destination register and value.
    typedef struct packed {
        logic [c_addr_w-1:0] addr;
        logic [c_data_w-1:0] data;
    } wb_req_t;

    // NORMAL: lanes have priority, buffered returns fill spare ports.
    // DRAIN : lane 1 is held off so the oldest buffered return retires.
    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_t;

    // Register 0 is hard-wired; a write to it retires without a write enable.
    function automatic logic has_rf_write(input wb_req_t req);
        return req.addr != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_fifo
// Description : Order-preserving buffer for long-latency write-back returns.
//               The head entry is presented combinationally; push and pop may
//               occur in the same cycle.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_push/i_push_data - enqueue one return
//               i_pop              - dequeue the head entry
//               o_head             - current head entry (valid if o_count!=0)
//               o_count            - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  wb_req_t                i_push_data,
    input  logic                   i_pop,
    output wb_req_t                o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    wb_req_t              r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(i_push) - c_cnt_w'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !rst) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Merges two in-order lane writes and buffered long-latency
//               returns onto a two-port register file. Grants are zero-cycle
//               (combinational); the return buffer, starvation counter and
//               NORMAL/DRAIN state are registered. Same-cycle writes are laid
//               out oldest-first so port 2 (which wins on equal address)
//               always carries the youngest value.
// Ports       : clk, reset                    - clock, sync active-high reset
//               l0_valid/waddr/wdata, l0_ready - lane 0 (older) request/grant
//               l1_valid/waddr/wdata, l1_ready - lane 1 (younger) request/grant
//               lr_valid/waddr/wdata, lr_ready - long-latency return/accept
//               we_01/waddr_01/wdata_01        - register-file write port 1
//               we_02/waddr_02/wdata_02        - register-file write port 2
//               fifo_count                     - return buffer occupancy
// Options     : RF_WB_BYPASS_EN - when defined, a return arriving at an empty
//               buffer is written straight to a free port in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = c_default_starve_limit
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        l0_valid,
    input  logic [c_addr_w-1:0]         l0_waddr,
    input  logic [c_data_w-1:0]         l0_wdata,
    output logic                        l0_ready,
    input  logic                        l1_valid,
    input  logic [c_addr_w-1:0]         l1_waddr,
    input  logic [c_data_w-1:0]         l1_wdata,
    output logic                        l1_ready,
    input  logic                        lr_valid,
    input  logic [c_addr_w-1:0]         lr_waddr,
    input  logic [c_data_w-1:0]         lr_wdata,
    output logic                        lr_ready,
    output logic                        we_01,
    output logic [c_addr_w-1:0]         waddr_01,
    output logic [c_data_w-1:0]         wdata_01,
    output logic                        we_02,
    output logic [c_addr_w-1:0]         waddr_02,
    output logic [c_data_w-1:0]         wdata_02,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_stv_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_stv_w-1:0]  r_starve;
    logic [c_stv_w-1:0]  w_starve_nxt;
    logic [c_cnt_w-1:0]  w_count_nxt;

    wb_req_t w_l0_req;
    wb_req_t w_l1_req;
    wb_req_t w_lr_req;
    wb_req_t w_fifo_head;
    wb_req_t w_head_req;
    wb_req_t w_p1;
    wb_req_t w_p2;
    logic    w_p1_v;
    logic    w_p2_v;

    logic w_fifo_empty;
    logic w_bypass_ok;
    logic w_head_valid;
    logic w_l0_gnt;
    logic w_l1_gnt;
    logic w_head_gnt;
    logic w_push;
    logic w_pop;

    assign w_l0_req = '{addr: l0_waddr, data: l0_wdata};
    assign w_l1_req = '{addr: l1_waddr, data: l1_wdata};
    assign w_lr_req = '{addr: lr_waddr, data: lr_wdata};

    assign w_fifo_empty = (fifo_count == '0);

`ifdef RF_WB_BYPASS_EN
    // An arriving return stands in for the missing head when the buffer is
    // empty; it is the oldest write in flight, so it takes the head's slot.
    assign w_bypass_ok = w_fifo_empty & lr_valid;
`else
    assign w_bypass_ok = 1'b0;
`endif

    assign w_head_valid = ~w_fifo_empty | w_bypass_ok;
    assign w_head_req   = w_fifo_empty ? w_lr_req : w_fifo_head;

    // ---------------------------------------------------------------- grants
    assign w_l0_gnt   = ~reset & l0_valid;
    assign w_l1_gnt   = ~reset & l1_valid & (r_state == NORMAL);
    assign w_head_gnt = ~reset & w_head_valid &
                        ((r_state == DRAIN) | ~(l0_valid & l1_valid));

    assign l0_ready = w_l0_gnt;
    assign l1_ready = w_l1_gnt;
    // Acceptance uses the pre-pop occupancy: a full buffer refuses even when
    // the head retires in the same cycle.
    assign lr_ready = ~reset & (fifo_count < c_cnt_w'(FIFO_DEPTH));

    // A granted head with an empty buffer can only be a bypassed return.
    assign w_pop  = w_head_gnt & ~w_fifo_empty;
    assign w_push = lr_valid & lr_ready & ~(w_head_gnt & w_fifo_empty);

    assign w_count_nxt = fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

    // ----------------------------------------------------- port placement
    // At most two writes are granted. The older goes to port 1 and the
    // younger to port 2; a lone write uses port 1.
    always_comb begin
        w_p1   = '0;
        w_p2   = '0;
        w_p1_v = 1'b0;
        w_p2_v = 1'b0;
        if (w_head_gnt) begin
            w_p1   = w_head_req;
            w_p1_v = 1'b1;
            if (w_l0_gnt) begin
                w_p2   = w_l0_req;
                w_p2_v = 1'b1;
            end else if (w_l1_gnt) begin
                w_p2   = w_l1_req;
                w_p2_v = 1'b1;
            end
        end else if (w_l0_gnt) begin
            w_p1   = w_l0_req;
            w_p1_v = 1'b1;
            if (w_l1_gnt) begin
                w_p2   = w_l1_req;
                w_p2_v = 1'b1;
            end
        end else if (w_l1_gnt) begin
            w_p1   = w_l1_req;
            w_p1_v = 1'b1;
        end
    end

    assign we_01    = w_p1_v & has_rf_write(w_p1);
    assign waddr_01 = w_p1.addr;
    assign wdata_01 = w_p1.data;
    assign we_02    = w_p2_v & has_rf_write(w_p2);
    assign waddr_02 = w_p2.addr;
    assign wdata_02 = w_p2.data;

    // ------------------------------------------------ starvation / state
    always_comb begin
        w_starve_nxt = r_starve;
        w_state_nxt  = r_state;

        if (w_fifo_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (r_starve != c_stv_w'(STARVE_LIMIT)) begin
            w_starve_nxt = r_starve + c_stv_w'(1);
        end

        case (r_state)
            NORMAL: begin
                if ((w_starve_nxt == c_stv_w'(STARVE_LIMIT)) ||
                    (w_count_nxt == c_cnt_w'(FIFO_DEPTH))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_head_gnt || w_fifo_empty) begin
                    w_state_nxt = NORMAL;
                end
            end
            default: w_state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= NORMAL;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // ------------------------------------------------------ return buffer
    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_lr_req),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_count     (fifo_count)
    );

endmodule
`default_nettype wire
